// File: rtl/vectorfpga_pkg.sv
// Shared constants and types for the vector display return channel.
package vectorfpga_pkg;

    // First byte of every frame-done report.
    localparam logic [7:0] REPORT_HDR = 8'hF0;

    // Bits on the wire per UART byte: start + 8 data + stop.
    localparam int UART_FRAME_BITS = 10;

    // Report sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } rpt_state_e;

    // High report byte: the top three bits of the 11-bit point count.
    function automatic logic [7:0] report_hi(input logic [10:0] n);
        return {5'b0_0000, n[10:8]};
    endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// User byte write port of the status transmitter.
interface uart_status_tx_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_byte, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 shifter: one byte per load, each bit held CLKS_PER_BIT clocks.
// stop_end marks the final clock of the stop bit so a following byte can be
// loaded on that edge without an idle gap.
module uart_tx_serializer
    import vectorfpga_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic       tx,
    output logic       shifting,
    output logic       stop_end
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(UART_FRAME_BITS - 1);

    logic [8:0]  shift_q, shift_d;   // {stop, d7..d0}, consumed LSB first
    logic [3:0]  bit_q, bit_d;       // 0 = start ... 9 = stop
    logic [15:0] baud_q, baud_d;
    logic        tx_q, tx_d;
    logic        shifting_q, shifting_d;
    logic        bit_end_s;

    assign bit_end_s = shifting_q && (baud_q == BAUD_LAST);
    assign stop_end  = bit_end_s && (bit_q == LAST_BIT);
    assign tx        = tx_q;
    assign shifting  = shifting_q;

    // Next-state: load a new frame, advance baud/bit counters, or idle high.
    always_comb begin
        shift_d    = shift_q;
        bit_d      = bit_q;
        baud_d     = baud_q;
        tx_d       = tx_q;
        shifting_d = shifting_q;
        if (load) begin
            shift_d    = {1'b1, load_byte};
            bit_d      = 4'd0;
            baud_d     = 16'd0;
            tx_d       = 1'b0;
            shifting_d = 1'b1;
        end else if (shifting_q) begin
            if (bit_end_s) begin
                baud_d = 16'd0;
                if (bit_q == LAST_BIT) begin
                    shifting_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 16'd1;
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    // Serializer state; reset forces the line high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= 9'h1FF;
            bit_q      <= 4'd0;
            baud_q     <= 16'd0;
            tx_q       <= 1'b1;
            shifting_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            shifting_q <= shifting_d;
        end
    end

endmodule

// File: rtl/uart_status_tx.sv
// UART return channel: byte FIFO shared by user bytes and 3-byte frame-done
// reports (F0, n[10:8], n[7:0]), drained by an 8N1 serializer.
module uart_status_tx
    import vectorfpga_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_status_tx_if.slave user,
    input  logic            frame_done,
    input  logic [10:0]     num_points,
    output logic            tx,
    output logic            busy,
    output logic [7:0]      dropped
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] RPT_LEN = (AW + 1)'(3);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] count_s, free_s;
    logic        full_s, empty_s, room_s;
    logic        wr_s, pop_s, user_wr_s;
    logic [7:0]  wr_data_s, rd_data_s;

    rpt_state_e  state_q, state_d;
    logic        pend_q, pend_d;
    logic [10:0] n_q, n_d;
    logic [7:0]  dropped_q, dropped_d;
    logic        rdy_q;
    logic        fsm_wr_s;
    logic [7:0]  fsm_data_s;

    logic        ser_shifting_s, ser_stop_end_s;

    assign count_s   = wptr_q - rptr_q;
    assign free_s    = DEPTH_C - count_s;
    assign full_s    = (count_s == DEPTH_C);
    assign empty_s   = (wptr_q == rptr_q);
    assign room_s    = (free_s >= RPT_LEN);
    assign rd_data_s = mem_q[rptr_q[AW-1:0]];

    // Reports own the FIFO outside IDLE and in any cycle frame_done is high.
    assign user.tx_ready = rdy_q && !full_s && (state_q == ST_IDLE)
                           && !pend_q && !frame_done;
    assign user_wr_s = user.tx_valid && user.tx_ready;
    assign wr_s      = fsm_wr_s || user_wr_s;
    assign wr_data_s = fsm_wr_s ? fsm_data_s : user.tx_byte;

    // Pop when the serializer is idle or finishing its stop bit.
    assign pop_s = !empty_s && (!ser_shifting_s || ser_stop_end_s);

    assign busy    = !empty_s || ser_shifting_s;
    assign dropped = dropped_q;

    // Report sequencer, drop counter and FIFO pointer next-state.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        n_d        = n_q;
        fsm_wr_s   = 1'b0;
        fsm_data_s = REPORT_HDR;
        dropped_d  = dropped_q;

        if (frame_done && ((state_q != ST_IDLE) || pend_q)) begin
            if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end else begin
                dropped_d = dropped_q;
            end
        end else begin
            dropped_d = dropped_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done || pend_q) begin
                    if (frame_done && !pend_q) begin
                        n_d = num_points;
                    end else begin
                        n_d = n_q;
                    end
                    if (room_s) begin
                        fsm_wr_s   = 1'b1;
                        fsm_data_s = REPORT_HDR;
                        pend_d     = 1'b0;
                        state_d    = ST_HI;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = ST_HDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (room_s) begin
                    fsm_wr_s   = 1'b1;
                    fsm_data_s = REPORT_HDR;
                    pend_d     = 1'b0;
                    state_d    = ST_HI;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_HI: begin
                fsm_wr_s   = 1'b1;
                fsm_data_s = report_hi(n_q);
                state_d    = ST_LO;
            end
            ST_LO: begin
                fsm_wr_s   = 1'b1;
                fsm_data_s = n_q[7:0];
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase

        if (wr_s) begin
            wptr_d = wptr_q + (AW + 1)'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + (AW + 1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Control registers; reset empties the FIFO and idles the sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            n_q       <= 11'd0;
            dropped_q <= 8'd0;
            rdy_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            state_q   <= state_d;
            pend_q    <= pend_d;
            n_q       <= n_d;
            dropped_q <= dropped_d;
            rdy_q     <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_s;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (pop_s),
        .load_byte (rd_data_s),
        .tx        (tx),
        .shifting  (ser_shifting_s),
        .stop_end  (ser_stop_end_s)
    );

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A line monitor decodes every byte on tx and records its start cycle.
module tb_uart_status_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done = 1'b0;
    logic [10:0] num_points = 11'd0;
    wire         tx;
    wire         busy;
    wire  [7:0]  dropped;

    uart_status_tx_if u_if ();

    uart_status_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .user       (u_if),
        .frame_done (frame_done),
        .num_points (num_points),
        .tx         (tx),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] rx_q[$];
    int         st_q[$];
    int         frame_err = 0;
    logic [7:0] mon_b;
    int         mon_st;
    bit         mon_ok;

    // Line monitor: samples each bit near its start + 1 clock.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                mon_st = cyc;
                mon_ok = 1'b1;
                mon_b  = 8'h00;
                for (int i = 0; i < 10; i++) begin
                    repeat ((i == 0) ? 1 : CPB) @(negedge clk);
                    if (reset) begin
                        mon_ok = 1'b0;
                        break;
                    end
                    if (i == 0 && tx !== 1'b0) frame_err++;
                    if (i >= 1 && i <= 8) mon_b[i-1] = tx;
                    if (i == 9 && tx !== 1'b1) frame_err++;
                end
                if (mon_ok) begin
                    rx_q.push_back(mon_b);
                    st_q.push_back(mon_st);
                    repeat (CPB - 2) @(negedge clk);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        u_if.tx_byte  = b;
        u_if.tx_valid = 1'b1;
        n = 0;
        while (u_if.tx_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            chk_cnt++;
            $display("FAIL send_timeout: tx_ready=%b want 1", u_if.tx_ready);
        end
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    task automatic pulse_frame(input logic [10:0] n);
        frame_done = 1'b1;
        num_points = n;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (n >= 20000) $display("FAIL idle_timeout: busy=%b want 0", busy);
        else pass_cnt++;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #12;
        chk_cnt++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx); else pass_cnt++;
        chk_cnt++; if (u_if.tx_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", u_if.tx_ready); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (dropped !== 8'd0) $display("FAIL rst_dropped: got %0d want 0", dropped); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_cnt++; if (u_if.tx_ready !== 1'b0) $display("FAIL ready_pre_edge: got %b want 0", u_if.tx_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (u_if.tx_ready !== 1'b1) $display("FAIL ready_first_edge: got %b want 1", u_if.tx_ready); else pass_cnt++;
    endtask

    task automatic test_single_byte();
        logic [9:0] pat;
        int bad;
        pat = 10'b11_0100_1010;   // bit k = line level during bit slot k
        u_if.tx_byte  = 8'hA5;
        u_if.tx_valid = 1'b1;
        chk_cnt++; if (u_if.tx_ready !== 1'b1) $display("FAIL a5_ready: got %b want 1", u_if.tx_ready); else pass_cnt++;
        tick();
        u_if.tx_valid = 1'b0;
        chk_cnt++; if (tx !== 1'b1) $display("FAIL a5_tx_at_N: got %b want 1", tx); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL a5_busy_at_N: got %b want 1", busy); else pass_cnt++;
        tick();
        bad = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (tx !== pat[k / CPB]) begin
                bad++;
                $display("FAIL a5_bit: cycle %0d got %b want %b", k, tx, pat[k / CPB]);
            end
            if (k == 10 * CPB - 1) begin
                chk_cnt++; if (busy !== 1'b1) $display("FAIL a5_busy_last: got %b want 1", busy); else pass_cnt++;
            end
            tick();
        end
        chk_cnt++; if (bad != 0) $display("FAIL a5_pattern: got %0d bad cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL a5_busy_end: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (tx !== 1'b1) $display("FAIL a5_tx_end: got %b want 1", tx); else pass_cnt++;
        repeat (3) tick();
        chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL a5_rx: got %0d bytes want 1 (A5)", rx_q.size()); else pass_cnt++;
        rx_q.delete();
        st_q.delete();
    endtask

    task automatic test_report();
        pulse_frame(11'h5C3);
        wait_idle();
        chk_cnt++; if (rx_q.size() != 3) $display("FAIL rpt_count: got %0d want 3", rx_q.size()); else pass_cnt++;
        if (rx_q.size() == 3) begin
            chk_cnt++; if (rx_q[0] !== 8'hF0) $display("FAIL rpt_b0: got %h want f0", rx_q[0]); else pass_cnt++;
            chk_cnt++; if (rx_q[1] !== 8'h05) $display("FAIL rpt_b1: got %h want 05", rx_q[1]); else pass_cnt++;
            chk_cnt++; if (rx_q[2] !== 8'hC3) $display("FAIL rpt_b2: got %h want c3", rx_q[2]); else pass_cnt++;
            chk_cnt++; if (st_q[2] - st_q[0] != 20 * CPB) $display("FAIL rpt_gapless: got %0d want %0d", st_q[2] - st_q[0], 20 * CPB); else pass_cnt++;
        end
        chk_cnt++; if (dropped !== 8'd0) $display("FAIL rpt_dropped: got %0d want 0", dropped); else pass_cnt++;
        rx_q.delete();
        st_q.delete();
    endtask

    task automatic test_collision();
        logic [7:0] exp_b [4];
        exp_b = '{8'hF0, 8'h00, 8'h07, 8'h41};
        u_if.tx_byte  = 8'h41;
        u_if.tx_valid = 1'b1;
        frame_done    = 1'b1;
        num_points    = 11'd7;
        #1;
        chk_cnt++; if (u_if.tx_ready !== 1'b0) $display("FAIL coll_ready: got %b want 0", u_if.tx_ready); else pass_cnt++;
        tick();
        frame_done = 1'b0;
        send_byte(8'h41);
        wait_idle();
        chk_cnt++; if (rx_q.size() != 4) $display("FAIL coll_count: got %0d want 4", rx_q.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            chk_cnt++; if (rx_q[i] !== exp_b[i]) $display("FAIL coll_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); else pass_cnt++;
        end
        rx_q.delete();
        st_q.delete();
    endtask

    task automatic test_hdr_wait();
        int bad;
        for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i));
        pulse_frame(11'd3);
        chk_cnt++; if (u_if.tx_ready !== 1'b0) $display("FAIL hdr_ready: got %b want 0", u_if.tx_ready); else pass_cnt++;
        wait_idle();
        chk_cnt++; if (rx_q.size() != 18) $display("FAIL hdr_count: got %0d want 18", rx_q.size()); else pass_cnt++;
        if (rx_q.size() == 18) begin
            bad = 0;
            for (int i = 0; i < 15; i++) if (rx_q[i] !== 8'h10 + 8'(i)) bad++;
            chk_cnt++; if (bad != 0) $display("FAIL hdr_user_bytes: got %0d wrong want 0", bad); else pass_cnt++;
            chk_cnt++; if (rx_q[15] !== 8'hF0) $display("FAIL hdr_b0: got %h want f0", rx_q[15]); else pass_cnt++;
            chk_cnt++; if (rx_q[16] !== 8'h00) $display("FAIL hdr_b1: got %h want 00", rx_q[16]); else pass_cnt++;
            chk_cnt++; if (rx_q[17] !== 8'h03) $display("FAIL hdr_b2: got %h want 03", rx_q[17]); else pass_cnt++;
            chk_cnt++; if (st_q[17] - st_q[0] != 17 * 10 * CPB) $display("FAIL hdr_gapless: got %0d want %0d", st_q[17] - st_q[0], 170 * CPB); else pass_cnt++;
        end
        chk_cnt++; if (dropped !== 8'd0) $display("FAIL hdr_dropped: got %0d want 0", dropped); else pass_cnt++;
        rx_q.delete();
        st_q.delete();
    endtask

    task automatic test_dropped();
        int exp_drop [4];
        exp_drop = '{81, 161, 241, 255};
        frame_done = 1'b1;
        num_points = 11'h2AB;
        tick();
        num_points = 11'h155;
        tick();
        frame_done = 1'b0;
        wait_idle();
        chk_cnt++; if (dropped !== 8'd1) $display("FAIL drop_pair: got %0d want 1", dropped); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != 3) $display("FAIL drop_pair_count: got %0d want 3", rx_q.size()); else pass_cnt++;
        if (rx_q.size() == 3) begin
            chk_cnt++; if (rx_q[1] !== 8'h02 || rx_q[2] !== 8'hAB) $display("FAIL drop_pair_n: got %h%h want 02ab", rx_q[1], rx_q[2]); else pass_cnt++;
        end
        rx_q.delete();
        st_q.delete();
        // Each round: fill the FIFO, one report parks in HDR, 80 more pulses drop.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 17; i++) send_byte(8'h80 + 8'(i));
            frame_done = 1'b1;
            num_points = 11'h7FF;
            tick();
            num_points = 11'h001;
            repeat (80) tick();
            frame_done = 1'b0;
            chk_cnt++; if (dropped !== 8'(exp_drop[r])) $display("FAIL drop_round%0d: got %0d want %0d", r, dropped, exp_drop[r]); else pass_cnt++;
            wait_idle();
            chk_cnt++; if (rx_q.size() != 20) $display("FAIL drop_round%0d_count: got %0d want 20", r, rx_q.size()); else pass_cnt++;
            if (rx_q.size() == 20) begin
                chk_cnt++;
                if (rx_q[17] !== 8'hF0 || rx_q[18] !== 8'h07 || rx_q[19] !== 8'hFF)
                    $display("FAIL drop_round%0d_rpt: got %h %h %h want f0 07 ff", r, rx_q[17], rx_q[18], rx_q[19]);
                else pass_cnt++;
            end
            rx_q.delete();
            st_q.delete();
        end
    endtask

    task automatic test_reset_mid_byte();
        int bad;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (16) tick();
        chk_cnt++; if (tx !== 1'b0) $display("FAIL mid_pre_tx: got %b want 0", tx); else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++; if (tx !== 1'b1) $display("FAIL mid_tx: got %b want 1", tx); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (u_if.tx_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", u_if.tx_ready); else pass_cnt++;
        chk_cnt++; if (dropped !== 8'd0) $display("FAIL mid_dropped: got %0d want 0", dropped); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL mid_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (rx_q.size() != 0) $display("FAIL mid_rx: got %0d bytes want 0", rx_q.size()); else pass_cnt++;
    endtask

    task automatic test_framing();
        chk_cnt++; if (frame_err != 0) $display("FAIL framing: got %0d errors want 0", frame_err); else pass_cnt++;
    endtask

    initial begin
        u_if.tx_byte  = 8'h00;
        u_if.tx_valid = 1'b0;
        test_reset();
        test_single_byte();
        test_report();
        test_collision();
        test_hdr_wait();
        test_dropped();
        test_reset_mid_byte();
        test_framing();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_status_tx.md
Name: uart_status_tx

Overview:
UART 8N1 transmitter giving the vector display a return channel to the host: the host side of the link runs in the opposite direction to the rx_buffer receive path.
- Sends a 3-byte frame-done report each time the point buffer finishes a pass; the host uses it for flow control before streaming the next frame.
- Also sends arbitrary single bytes from other blocks (debug, acknowledgements).
- Sits in the top level beside rx_buffer: frame_done is driven from done_drawing, num_points from num_pts.

Parameters:
CLKS_PER_BIT, 104, clocks per UART bit (12 MHz / 115200); legal range 4..65535.
FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 4.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-high reset.
tx_byte  in  8  user byte to send.
tx_valid  in  1  user byte strobe; accepted on a clk edge where tx_valid && tx_ready.
tx_ready  out  1  user write permitted: FIFO not full and report FSM in IDLE.
frame_done  in  1  one-cycle pulse at the end of a drawing pass.
num_points  in  11  point count, sampled in the same cycle as frame_done.
tx  out  1  UART serial output; idle high.
busy  out  1  high while the FIFO is non-empty or the serializer is shifting.
dropped  out  8  saturating count of lost frame_done reports.

Behaviour:
- Reset (asynchronous, immediate), including mid-byte: tx=1, tx_ready=0 during reset, busy=0, dropped=0, FIFO emptied, report FSM in IDLE, pending flag cleared. A partially sent byte is abandoned and no glitch low is driven.
- tx_ready rises on the first edge after reset deasserts.
- FIFO:
  - Synchronous, registered pointers, extra wrap bit for full/empty.
  - Write and read in the same cycle are both performed, including when full (read frees the slot).
- Report FSM, states IDLE, HDR, HI, LO:
  - IDLE: on frame_done, or with the pending flag set, if free slots >= 3:
    - latch num_points;
    - write 8'hF0 on that edge and go to HI;
    - clear the pending flag.
  - HDR: entered only when the pending flag is serviced while space is short. Wait until free slots >= 3, then write 8'hF0 and go to HI.
  - HI: write {5'b0, n[10:8]}, go to LO.
  - LO: write n[7:0], go to IDLE.
  - The 3 bytes are therefore contiguous in the FIFO; user bytes are never interleaved, because tx_ready=0 outside IDLE.
- frame_done arriving in IDLE with free slots < 3: set the pending flag, latch num_points, go to HDR.
- frame_done arriving while not in IDLE, or while the pending flag is already set: dropped increments, saturating at 255. The original latched count is kept.
- Same cycle frame_done and tx_valid in IDLE: the report wins. The user byte is not accepted, because tx_ready is combinationally 0 whenever frame_done=1.
- Serializer:
  - Idle, with the FIFO non-empty at edge N: it pops and loads at edge N+1, and tx=0 (start bit) from N+1.
  - Bit order: start, d0..d7 (LSB first), stop=1. Each bit lasts exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
  - If the FIFO is non-empty at the end of the stop bit, the next start bit follows immediately with no idle gap.
- Latency: a user byte written at edge N, into an empty system, produces its start bit at edge N+1.
- busy falls on the edge that ends the last stop bit when the FIFO is empty.
- Baud counter: 16-bit width, reset to 0 on every byte load.

Decomposition:
- Package vectorfpga_pkg holds:
  - REPORT_HDR = 8'hF0;
  - the report FSM state enum (IDLE, HDR, HI, LO);
  - the UART frame length constant 10.
- Sub-module uart_tx_serializer(clk, reset, load, byte, tx, shifting), parameterised by CLKS_PER_BIT; it owns the baud counter and shift register.
- The FIFO and report FSM stay in uart_status_tx.

Test Plan:
- Reset released, CLKS_PER_BIT=4, tx_byte=8'hA5 written at edge N -> tx pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting at edge N+1; busy low 40 cycles after N+1.
- frame_done with num_points=11'h5C3 -> bytes F0, 05, C3 sent back-to-back (30*CLKS_PER_BIT cycles, no gaps); dropped=0.
- Same cycle frame_done (num_points=7) and tx_valid (8'h41) -> tx_ready=0 that cycle; only F0, 00, 07 are sent; the bench retries 41, which is sent fourth.
- FIFO filled to 14/16 with user bytes, then frame_done with num_points=3 -> FSM goes to HDR and waits. After one byte drains, F0, 00, 03 are queued intact after the user bytes.
- Two frame_done pulses 1 cycle apart, then 300 pulses while busy -> one report sent; dropped saturates at 255.
- reset asserted mid-byte (bit d3) -> tx=1 in the same cycle; FIFO empty, busy=0; nothing further is sent after release.
